rr_grant_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource between 16 requesters.
- Issues a registered one-hot grant plus its 8-bit binary index, using the same one-hot/index convention as the lab encoder datapath (index 8'hFF = none).
- Sits between requester logic and the shared resource; owner holds the grant until it releases.

---
 rtl/rr_grant_arbiter_pkg.sv | 26 ++
 rtl/rr_grant_arbiter_pick.sv | 39 +++
 rtl/rr_grant_arbiter.sv | 136 +++++++++++++
 tb/tb_rr_grant_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter_pkg
// Shared constants and types for the round-robin grant arbiter.
//   N            : number of requesters (one-hot grant width)
//   IDX_W        : width of the binary grant index
//   PTR_W        : width of the round-robin priority pointer
//   IDX_NONE     : index value reported when nothing is granted
//   MAX_HOLD_DEF : default forced-release limit (optional timeout feature)
//   HOLD_W       : width of the hold counter (optional timeout feature)
//   state_e      : arbiter FSM states
// ---------------------------------------------------------------------------
package rr_grant_arbiter_pkg;

   localparam int N            = 16;
   localparam int IDX_W        = 8;
   localparam int PTR_W        = $clog2(N);
   localparam logic [IDX_W-1:0] IDX_NONE = 8'hFF;
   localparam int MAX_HOLD_DEF = 255;
   localparam int HOLD_W       = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_e;

endpackage

// File: rtl/rr_grant_arbiter_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority selector. Scans req starting at ptr and
// wrapping modulo N; the first set bit wins.
// Ports:
//   req_i      [N-1:0]     request vector
//   ptr_i      [PTR_W-1:0] highest-priority position for this scan
//   pick_o     [N-1:0]     one-hot winner, zero when no request
//   pick_idx_o [IDX_W-1:0] binary winner index, IDX_NONE when no request
//   any_o                  at least one request present
// ---------------------------------------------------------------------------
module rr_pick
   import rr_grant_arbiter_pkg::*;
(
   input  logic [N-1:0]     req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N-1:0]     pick_o,
   output logic [IDX_W-1:0] pick_idx_o,
   output logic             any_o
);

   int k;

   always_comb begin
      pick_o     = '0;
      pick_idx_o = IDX_NONE;
      any_o      = 1'b0;
      k          = 0;
      for (int i = 0; i < N; i++) begin
         k = (int'(ptr_i) + i) % N;
         if (!any_o && req_i[k]) begin
            any_o      = 1'b1;
            pick_o[k]  = 1'b1;
            pick_idx_o = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter
// Round-robin arbiter sharing one resource among N requesters. The owner
// keeps the grant until it pulses done or drops its request; every release
// is followed by one dead cycle before the next arbitration.
// Ports:
//   clk        system clock (posedge)
//   rst        synchronous active-high reset
//   req        [N-1:0]     request vector
//   done       release pulse from the current owner
//   gnt        [N-1:0]     registered one-hot grant, zero when idle
//   gnt_idx    [IDX_W-1:0] binary index of the owner, 8'hFF when idle
//   gnt_valid  high while a grant is held
//   timeout    one-cycle pulse after a forced release
// Optional feature, enabled by defining RR_GRANT_ARBITER_TIMEOUT_EN:
//   a hold counter forces a release after MAX_HOLD busy cycles and pulses
//   timeout. Without it, timeout is tied low and grants are held forever.
// ---------------------------------------------------------------------------
module rr_grant_arbiter
   import rr_grant_arbiter_pkg::*;
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
#(
   parameter int MAX_HOLD = MAX_HOLD_DEF
)
`endif
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req,
   input  logic             done,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   state_e           state_q;
   logic [N-1:0]     gnt_q;
   logic [IDX_W-1:0] gnt_idx_q;
   logic             gnt_valid_q;
   logic [PTR_W-1:0] ptr_q;

   logic [N-1:0]     pick;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_any;

   logic [PTR_W-1:0] owner;
   logic [PTR_W-1:0] ptr_d;
   logic             norm_rel;
   logic             tmo_hit;
   logic             rel;

   rr_pick u_pick (
      .req_i      (req),
      .ptr_i      (ptr_q),
      .pick_o     (pick),
      .pick_idx_o (pick_idx),
      .any_o      (pick_any)
   );

   // While BUSY the index register always holds a valid 0..N-1 owner.
   assign owner    = gnt_idx_q[PTR_W-1:0];
   assign ptr_d    = (owner == PTR_W'(N - 1)) ? '0 : owner + PTR_W'(1);
   // done and a withdrawn request together still make a single release.
   assign norm_rel = done | ~(|(req & gnt_q));

`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   logic [HOLD_W-1:0] hold_q;
   logic              timeout_q;

   // A normal release in the same cycle wins over the forced one.
   assign tmo_hit = ~norm_rel & (hold_q == HOLD_LAST);
   assign timeout = timeout_q;
`else
   assign tmo_hit = 1'b0;
   assign timeout = 1'b0;
`endif

   assign rel = norm_rel | tmo_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_idx_q   <= IDX_NONE;
         gnt_valid_q <= 1'b0;
         ptr_q       <= '0;
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
         hold_q      <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  gnt_q       <= pick;
                  gnt_idx_q   <= pick_idx;
                  gnt_valid_q <= 1'b1;
                  state_q     <= BUSY;
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
                  hold_q      <= '0;
`endif
               end
            end
            BUSY: begin
               if (rel) begin
                  gnt_q       <= '0;
                  gnt_idx_q   <= IDX_NONE;
                  gnt_valid_q <= 1'b0;
                  ptr_q       <= ptr_d;
                  state_q     <= IDLE;
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
                  timeout_q   <= tmo_hit;
`endif
               end
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
               else begin
                  hold_q <= hold_q + HOLD_W'(1);
               end
`endif
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
module tb_rr_grant_arbiter;

   localparam int NR = 16;
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
   localparam int TB_MAX_HOLD = 4;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [NR-1:0] req;
   logic          done;
   logic [NR-1:0] gnt;
   logic [7:0]    gnt_idx;
   logic          gnt_valid;
   logic          timeout;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
   rr_grant_arbiter #(.MAX_HOLD(TB_MAX_HOLD)) dut (
`else
   rr_grant_arbiter dut (
`endif
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   // Behavioural model: who owns the resource, where the next search starts.
   int m_owner = -1;   // -1 = nobody
   int m_ptr   = 0;
   int m_hold  = 0;
   bit m_tout  = 1'b0;

   always @(posedge clk) begin
      bit normal;
      m_tout = 1'b0;
      if (rst) begin
         m_owner = -1;
         m_ptr   = 0;
         m_hold  = 0;
      end else if (m_owner >= 0) begin
         normal = done || !req[m_owner];
         if (normal) begin
            m_ptr   = (m_owner + 1) % NR;
            m_owner = -1;
         end
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
         else if (m_hold == TB_MAX_HOLD - 1) begin
            m_ptr   = (m_owner + 1) % NR;
            m_owner = -1;
            m_tout  = 1'b1;
         end else begin
            m_hold++;
         end
`endif
      end else begin
         for (int s = 0; s < NR; s++) begin
            if (m_owner < 0 && req[(m_ptr + s) % NR]) m_owner = (m_ptr + s) % NR;
         end
         m_hold = 0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, sampled on the falling edge.
   always @(negedge clk) begin
      logic [NR-1:0] e_gnt;
      logic [7:0]    e_idx;
      if (chk_en) begin
         e_gnt = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
         e_idx = (m_owner < 0) ? 8'hFF : 8'(m_owner);
         check("gnt", 32'(gnt), 32'(e_gnt));
         check("gnt_idx", 32'(gnt_idx), 32'(e_idx));
         check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
         check("timeout", 32'(timeout), 32'(m_tout));
      end
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   int exp_rot [5] = '{0, 15, 0, 15, 0};

   initial begin
      rst  = 1'b1;
      req  = '0;
      done = 1'b0;
      step(2);
      chk_en = 1'b1;
      rst    = 1'b0;

      // Reset then idle
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_idx", 32'(gnt_idx), 32'hFF);
      check("rst_valid", 32'(gnt_valid), 32'h0);
      check("rst_tout", 32'(timeout), 32'h0);
      step(2);
      check("idle_idx", 32'(gnt_idx), 32'hFF);

      // Single request, release by done, next search starts at 5
      req = 16'h0010;
      step(1);
      check("single_gnt", 32'(gnt), 32'h0010);
      check("single_idx", 32'(gnt_idx), 32'h04);
      done = 1'b1;
      req  = 16'h0FFF;           // others ignored while busy
      step(1);
      done = 1'b0;
      check("done_gnt", 32'(gnt), 32'h0);
      check("done_idx", 32'(gnt_idx), 32'hFF);
      req = 16'h0021;
      step(1);
      check("ptr5_idx", 32'(gnt_idx), 32'h05);
      done = 1'b1;               // done with withdrawn request: one release
      req  = 16'h0000;
      step(1);
      done = 1'b0;
      check("dual_rel_idx", 32'(gnt_idx), 32'hFF);
      done = 1'b1;               // done while idle is ignored
      step(1);
      done = 1'b0;
      check("idle_done_idx", 32'(gnt_idx), 32'hFF);

      // Round-robin rotation from a fresh pointer
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      req = 16'h8001;
      step(1);
      for (int g = 0; g < 5; g++) begin
         check("rot_idx", 32'(gnt_idx), 32'(exp_rot[g]));
         done = 1'b1;
         step(1);
         done = 1'b0;
         check("rot_dead", 32'(gnt), 32'h0);
         step(1);
      end

      // Owner withdraw
      req = '0;
      step(2);
      req = 16'h0008;
      step(1);
      check("wd_idx", 32'(gnt_idx), 32'h03);
      req = 16'h0000;
      step(1);
      check("wd_gnt", 32'(gnt), 32'h0);
      req = 16'h0019;
      step(1);
      check("wd_ptr4", 32'(gnt_idx), 32'h04);

      // Reset mid-grant
      req = '0;
      step(2);
      req = 16'h0080;
      step(1);
      check("mid_idx", 32'(gnt_idx), 32'h07);
      rst = 1'b1;
      req = 16'h0282;
      step(1);
      rst = 1'b0;
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      check("mid_rst_idx", 32'(gnt_idx), 32'hFF);
      req = 16'h0282;
      step(1);
      check("post_rst_idx", 32'(gnt_idx), 32'h01);

      // Long hold with no release
      req = 16'h0002;
`ifdef RR_GRANT_ARBITER_TIMEOUT_EN
      step(3);
      check("tmo_hold", 32'(gnt), 32'h0002);
      step(1);
      check("tmo_pulse", 32'(timeout), 32'h1);
      check("tmo_gnt", 32'(gnt), 32'h0);
      step(1);
      check("tmo_regrant", 32'(gnt_idx), 32'h01);
      check("tmo_once", 32'(timeout), 32'h0);
`else
      step(300);
      check("hold_idx", 32'(gnt_idx), 32'h01);
      check("hold_tout", 32'(timeout), 32'h0);
`endif

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
